stopwatch_100hz: RTL and testbench

- Downstream consumer of the 50 MHz -> 100 Hz divider: samples the divided clk_100Hz as data in the clk_MHz domain and derives a one-cycle centisecond tick.
- Runs a BCD MM:SS.cc stopwatch with start/stop, clear and lap-hold, and drives six BCD digits for the display mux.
- Everything is clocked by clk_MHz; clk_100Hz is never used as a clock.

---
 rtl/stopwatch_pkg.sv | 29 ++
 rtl/stopwatch_100hz_tick_detect.sv | 40 ++++
 rtl/stopwatch_100hz.sv | 138 +++++++++++++
 tb/tb_stopwatch_100hz.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and constants for the 100 Hz stopwatch slice.
//   sw_state_t  : run-control state (IDLE, RUN, PAUSE)
//   bcd_t       : one BCD display digit
//   DIGIT_MAX9 / DIGIT_MAX5 : highest legal value of a decimal / sexagesimal digit
//   NUM_DIGITS  : digits in MM:SS.cc, index 0 = cs_ones ... 5 = min_tens
//   digit_limit : wrap value for a given digit index
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t DIGIT_MAX9 = 4'd9;
    localparam bcd_t DIGIT_MAX5 = 4'd5;
    localparam int   NUM_DIGITS = 6;

    // Tens-of-seconds (3) and tens-of-minutes (5) count 0-5; all others 0-9.
    function automatic bcd_t digit_limit(input int idx);
        return (idx == 3 || idx == 5) ? DIGIT_MAX5 : DIGIT_MAX9;
    endfunction

endpackage

// File: rtl/stopwatch_100hz_tick_detect.sv
// -----------------------------------------------------------------------------
// hz_tick_detect
// Samples a slow divided clock as asynchronous data and produces a one-cycle
// registered pulse per rising edge, for any consumer in the clk_MHz domain.
//   clk_MHz   in  system clock
//   reset     in  synchronous active-high reset
//   clk_100Hz in  divided clock, treated as data
//   tick      out one-cycle pulse, SYNC_STAGES+1 cycles after the input rises
// SYNC_STAGES is meant to be 2 or 3. Input high and low phases must each last
// at least SYNC_STAGES+1 clk_MHz cycles for every edge to be seen exactly once.
// -----------------------------------------------------------------------------
module hz_tick_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_MHz,
    input  logic reset,
    input  logic clk_100Hz,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic                   tick_reg;

    always_ff @(posedge clk_MHz) begin
        if (reset) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
            tick_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], clk_100Hz};
            prev_reg <= sync_reg[SYNC_STAGES-1];
            // Registered edge detect: keeps the pulse glitch-free for fan-out.
            tick_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/stopwatch_100hz.sv
// -----------------------------------------------------------------------------
// stopwatch_100hz
// BCD MM:SS.cc stopwatch counting centisecond ticks derived from clk_100Hz.
//   clk_MHz, reset          : system clock, synchronous active-high reset
//   clk_100Hz               : divided clock, sampled as data only
//   start_stop, clear, lap  : one-cycle control pulses
//   cs_*/sec_*/min_*        : six BCD display digits
//   running                 : high in RUN
//   lap_active              : display frozen on a lap snapshot
//   tick_out                : one pulse per centisecond actually counted
//   overflow                : sticky, set on 59:59.99 -> 00:00.00
// -----------------------------------------------------------------------------
module stopwatch_100hz
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_MHz,
    input  logic       reset,
    input  logic       clk_100Hz,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] cs_tens,
    output logic [3:0] cs_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic       running,
    output logic       lap_active,
    output logic       tick_out,
    output logic       overflow
);

    logic                  tick;
    sw_state_t             state_reg;
    sw_state_t             state_next;
    bcd_t [NUM_DIGITS-1:0] count_reg;
    bcd_t [NUM_DIGITS-1:0] count_inc;
    bcd_t [NUM_DIGITS-1:0] snap_reg;
    bcd_t [NUM_DIGITS-1:0] disp;
    logic [NUM_DIGITS-1:0] at_limit;
    logic [NUM_DIGITS:0]   carry;
    logic                  count_en;
    logic                  clear_en;
    logic                  lap_active_reg;
    logic                  overflow_reg;
    logic                  tick_out_reg;

    hz_tick_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_tick_detect (
        .clk_MHz   (clk_MHz),
        .reset     (reset),
        .clk_100Hz (clk_100Hz),
        .tick      (tick)
    );

    // A tick is consumed only by the state held during its cycle, so a tick
    // coinciding with a stopping start_stop still counts.
    assign count_en = tick && (state_reg == RUN);
    assign clear_en = clear && (state_reg != RUN);
    assign carry[0] = count_en;

    // Carry into digit gi+1 is formed from the limit flags of all lower digits
    // directly rather than chained through carry[gi], so the vector has no
    // bit-to-bit dependency.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            localparam bcd_t LIMIT = digit_limit(gi);
            assign at_limit[gi]  = (count_reg[gi] == LIMIT);
            assign carry[gi+1]   = count_en && (&at_limit[gi:0]);
            assign count_inc[gi] = !carry[gi]   ? count_reg[gi] :
                                   at_limit[gi] ? '0            :
                                                  count_reg[gi] + 4'd1;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_stop) state_next = RUN;
            RUN:     if (start_stop) state_next = PAUSE;
            PAUSE: begin
                // clear has priority over a simultaneous restart
                if (clear)           state_next = IDLE;
                else if (start_stop) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_MHz) begin
        if (reset) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            snap_reg       <= '0;
            lap_active_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            tick_out_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tick_out_reg <= count_en;
            if (clear_en) begin
                count_reg      <= '0;
                overflow_reg   <= 1'b0;
                lap_active_reg <= 1'b0;
            end else begin
                count_reg <= count_inc;
                if (carry[NUM_DIGITS]) overflow_reg <= 1'b1;
                if (state_reg == RUN) begin
                    if (start_stop) begin
                        lap_active_reg <= 1'b0;
                    end else if (lap) begin
                        lap_active_reg <= ~lap_active_reg;
                        // Snapshot the post-tick value so a same-cycle tick is included.
                        if (!lap_active_reg) snap_reg <= count_inc;
                    end
                end
            end
        end
    end

    assign disp = lap_active_reg ? snap_reg : count_reg;

    assign cs_ones    = disp[0];
    assign cs_tens    = disp[1];
    assign sec_ones   = disp[2];
    assign sec_tens   = disp[3];
    assign min_ones   = disp[4];
    assign min_tens   = disp[5];
    assign running    = (state_reg == RUN);
    assign lap_active = lap_active_reg;
    assign tick_out   = tick_out_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_stopwatch_100hz.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_100hz
// Self-checking bench for stopwatch_100hz: directed sequences, a control-pulse
// vector table and a randomized run against a centisecond-count model.
// -----------------------------------------------------------------------------
module tb_stopwatch_100hz;

    localparam int SYNC_STAGES = 2;
    localparam int TICK_LAT    = SYNC_STAGES + 2; // rising edge -> count visible
    localparam int HALF        = 10;              // 20-cycle clk_100Hz period
    localparam int WRAP_CS     = 360000;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

    logic       clk_MHz = 1'b0;
    logic       reset = 1'b1;
    logic       clk_100Hz = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic       lap = 1'b0;
    logic [3:0] cs_tens, cs_ones, sec_tens, sec_ones, min_tens, min_ones;
    logic       running, lap_active, tick_out, overflow;
    logic [23:0] disp;

    int checks = 0;
    int failures = 0;
    int tick_total = 0;

    typedef struct {
        logic ss;
        logic cl;
        logic lp;
        logic exp_run;
        logic exp_lap;
        int   exp_cs;
    } vec_t;

    vec_t vecs [16];

    stopwatch_100hz #(
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_MHz    (clk_MHz),
        .reset      (reset),
        .clk_100Hz  (clk_100Hz),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .cs_tens    (cs_tens),
        .cs_ones    (cs_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .running    (running),
        .lap_active (lap_active),
        .tick_out   (tick_out),
        .overflow   (overflow)
    );

    always #5 clk_MHz = ~clk_MHz;

    assign disp = {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones};

    always @(negedge clk_MHz) begin
        if (tick_out === 1'b1) tick_total = tick_total + 1;
    end

    // MM:SS.cc digits of a centisecond count, by plain arithmetic.
    function automatic logic [23:0] bcd_of(input int cs);
        int m, s, c;
        m = cs / 6000;
        s = (cs / 100) % 60;
        c = cs % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input int cs, input logic run,
                             input logic lapa, input logic ovf);
        check({name, ".digits"}, {8'h0, disp}, {8'h0, bcd_of(cs)});
        check({name, ".running"}, {31'h0, running}, {31'h0, run});
        check({name, ".lap_active"}, {31'h0, lap_active}, {31'h0, lapa});
        check({name, ".overflow"}, {31'h0, overflow}, {31'h0, ovf});
        $display("seq %s: digits=%06h running=%0b lap=%0b ovf=%0b", name, disp, running,
                 lap_active, overflow);
    endtask

    task automatic step();
        @(posedge clk_MHz);
        #1;
    endtask

    task automatic pulse(input logic ss, input logic cl, input logic lp);
        start_stop = ss;
        clear      = cl;
        lap        = lp;
        step();
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
    endtask

    task automatic run_edges(input int n);
        repeat (n) begin
            clk_100Hz = 1'b1;
            repeat (HALF) step();
            clk_100Hz = 1'b0;
            repeat (HALF) step();
        end
    endtask

    // One clk_100Hz period with start_stop/lap landing on the cycle its tick is counted.
    task automatic edge_event(input string name, input logic ss, input logic lp);
        clk_100Hz = 1'b1;
        repeat (TICK_LAT - 1) step();
        start_stop = ss;
        lap        = lp;
        step();
        start_stop = 1'b0;
        lap        = 1'b0;
        check({name, ".tick_out"}, {31'h0, tick_out}, 32'h1);
        repeat (HALF - TICK_LAT) step();
        clk_100Hz = 1'b0;
        repeat (HALF) step();
    endtask

    initial begin
        int t0;
        int lat;
        int mode, live, snap, hz, phase_left;
        logic lap_on, ovf;
        int rise_q [$];

        // start_stop, clear, lap -> running, lap_active, digits (centiseconds)
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 37}; // lap in PAUSE ignored
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 37}; // resume
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 37}; // clear in RUN ignored
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 37}; // lap on
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 37}; // lap off
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 37}; // lap on
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 37}; // stop drops lap
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};  // clear -> IDLE
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};  // clear in IDLE
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};  // lap in IDLE ignored
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};  // run
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};  // pause at zero
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};  // clear beats start_stop
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};  // run
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};  // pause
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};  // clear -> IDLE

        // ---------------- reset ----------------
        reset = 1'b1;
        repeat (3) step();
        check_all("reset", 0, 1'b0, 1'b0, 1'b0);
        check("reset.tick_out", {31'h0, tick_out}, 32'h0);
        reset = 1'b0;
        step();

        // ---------------- first 100 edges ----------------
        pulse(1'b1, 1'b0, 1'b0);
        check("start.running", {31'h0, running}, 32'h1);
        t0 = tick_total;
        clk_100Hz = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (tick_out === 1'b1 && lat == 0) lat = k;
        end
        check("first_tick_latency", lat, TICK_LAT);
        repeat (HALF - 8) step();
        clk_100Hz = 1'b0;
        repeat (HALF) step();
        run_edges(99);
        check_all("count_100", 100, 1'b1, 1'b0, 1'b0);
        check("tick_pulses_100", tick_total - t0, 100);

        // ---------------- wrap / overflow ----------------
        force dut.count_reg = bcd_of(WRAP_CS - 10);
        step();
        release dut.count_reg;
        run_edges(9);
        check_all("at_59_59_99", WRAP_CS - 1, 1'b1, 1'b0, 1'b0);
        run_edges(1);
        check_all("wrap", 0, 1'b1, 1'b0, 1'b1);
        run_edges(3);
        check_all("after_wrap_sticky", 3, 1'b1, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        check_all("pause_after_wrap", 3, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        check_all("clear_after_wrap", 0, 1'b0, 1'b0, 1'b0);

        // ---------------- lap ----------------
        pulse(1'b1, 1'b0, 1'b0);
        run_edges(250);
        check_all("run_2_50", 250, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        check_all("lap_on", 250, 1'b1, 1'b1, 1'b0);
        run_edges(100);
        check_all("lap_hold", 250, 1'b1, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        check_all("lap_release", 350, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        check_all("lap_again", 350, 1'b1, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        check_all("stop_clears_lap", 350, 1'b0, 1'b0, 1'b0);

        // ---------------- stop and clear ----------------
        pulse(1'b0, 1'b1, 1'b0);
        check_all("clear_pause", 0, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        run_edges(37);
        pulse(1'b1, 1'b0, 1'b0);
        check_all("stop_0_37", 37, 1'b0, 1'b0, 1'b0);
        t0 = tick_total;
        run_edges(10);
        check_all("paused_hold", 37, 1'b0, 1'b0, 1'b0);
        check("paused_no_ticks", tick_total - t0, 0);

        // ---------------- control vector table ----------------
        for (int v = 0; v < 16; v++) begin
            pulse(vecs[v].ss, vecs[v].cl, vecs[v].lp);
            $display("vec %0d ss=%0b cl=%0b lp=%0b -> run=%0b lap=%0b digits=%06h",
                     v, vecs[v].ss, vecs[v].cl, vecs[v].lp, running, lap_active, disp);
            check($sformatf("vec%0d.running", v), {31'h0, running}, {31'h0, vecs[v].exp_run});
            check($sformatf("vec%0d.lap_active", v), {31'h0, lap_active}, {31'h0, vecs[v].exp_lap});
            check($sformatf("vec%0d.digits", v), {8'h0, disp}, {8'h0, bcd_of(vecs[v].exp_cs)});
            check($sformatf("vec%0d.overflow", v), {31'h0, overflow}, 32'h0);
        end

        // ---------------- simultaneous events ----------------
        pulse(1'b1, 1'b0, 1'b0);
        edge_event("stop_on_tick", 1'b1, 1'b0);
        check_all("stop_on_tick", 1, 1'b0, 1'b0, 1'b0);
        run_edges(2);
        check_all("stopped_after_tick", 1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        edge_event("lap_on_tick", 1'b0, 1'b1);
        check_all("lap_on_tick", 2, 1'b1, 1'b1, 1'b0);
        run_edges(1);
        check_all("lap_frozen", 2, 1'b1, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        check_all("lap_off_live", 3, 1'b1, 1'b0, 1'b0);

        // ---------------- reset mid-run at 12:34.56 ----------------
        force dut.count_reg = bcd_of(75456);
        step();
        release dut.count_reg;
        pulse(1'b0, 1'b0, 1'b1);
        check_all("preset_12_34_56", 75456, 1'b1, 1'b1, 1'b0);
        reset     = 1'b1;
        clk_100Hz = 1'b1;
        step();
        check_all("reset_midrun", 0, 1'b0, 1'b0, 1'b0);
        check("reset_midrun.tick_out", {31'h0, tick_out}, 32'h0);
        reset = 1'b0;
        t0 = tick_total;
        repeat (HALF - 1) step();
        clk_100Hz = 1'b0;
        repeat (HALF) step();
        run_edges(4);
        check_all("idle_after_reset", 0, 1'b0, 1'b0, 1'b0);
        check("idle_after_reset.ticks", tick_total - t0, 0);

        // ---------------- randomized run vs. model ----------------
        mode = M_IDLE; live = 0; snap = 0; lap_on = 1'b0; ovf = 1'b0;
        hz = 0; phase_left = 4;
        for (int i = 0; i < 3000; i++) begin
            logic ss_r, cl_r, lp_r, tk, counted;
            ss_r = ($urandom_range(0, 24) == 0);
            cl_r = ($urandom_range(0, 59) == 0);
            lp_r = ($urandom_range(0, 29) == 0);
            if (phase_left == 0) begin
                hz = (hz == 0) ? 1 : 0;
                phase_left = $urandom_range(SYNC_STAGES + 1, 8);
                if (hz == 1) rise_q.push_back(i + TICK_LAT - 1);
            end
            phase_left--;
            clk_100Hz  = (hz == 1);
            start_stop = ss_r;
            clear      = cl_r;
            lap        = lp_r;
            step();

            tk = (rise_q.size() > 0 && rise_q[0] == i);
            if (tk) void'(rise_q.pop_front());
            counted = tk && (mode == M_RUN);
            if (counted) begin
                live = (live + 1) % WRAP_CS;
                if (live == 0) ovf = 1'b1;
            end
            case (mode)
                M_IDLE: begin
                    if (cl_r) begin live = 0; ovf = 1'b0; end
                    if (ss_r) mode = M_RUN;
                end
                M_RUN: begin
                    if (ss_r) begin
                        mode = M_PAUSE;
                        lap_on = 1'b0;
                    end else if (lp_r) begin
                        if (!lap_on) snap = live;
                        lap_on = !lap_on;
                    end
                end
                default: begin
                    if (cl_r) begin
                        mode = M_IDLE; live = 0; ovf = 1'b0; lap_on = 1'b0;
                    end else if (ss_r) begin
                        mode = M_RUN;
                    end
                end
            endcase

            check("rand.digits", {8'h0, disp}, {8'h0, bcd_of(lap_on ? snap : live)});
            check("rand.running", {31'h0, running}, {31'h0, (mode == M_RUN)});
            check("rand.lap_active", {31'h0, lap_active}, {31'h0, lap_on});
            check("rand.tick_out", {31'h0, tick_out}, {31'h0, counted});
            check("rand.overflow", {31'h0, overflow}, {31'h0, ovf});
            if (i % 250 == 249)
                $display("rand cyc=%0d mode=%0d live=%0d lap=%0b", i, mode, live, lap_on);
        end
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
